// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - RV64I decode/issue stage with register scoreboard
// Decodes one instruction per cycle, stalls on RAW/WAW hazards, and holds a registered issue bundle for EX.
module decode_issue_stage #(
   parameter int ADDRSIZE = 5,
   parameter int WORDSIZE = 64,
   parameter int PCSIZE   = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_valid,
   output logic                if_ready,
   input  logic [31:0]         if_instr,
   input  logic [PCSIZE-1:0]   if_pc,
   output logic [ADDRSIZE-1:0] rs1,
   output logic [ADDRSIZE-1:0] rs2,
   input  logic [WORDSIZE-1:0] rs1data,
   input  logic [WORDSIZE-1:0] rs2data,
   input  logic                wb_valid,
   input  logic [ADDRSIZE-1:0] wb_rd,
   input  logic                flush,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [PCSIZE-1:0]   ex_pc,
   output logic [WORDSIZE-1:0] ex_rs1data,
   output logic [WORDSIZE-1:0] ex_rs2data,
   output logic [WORDSIZE-1:0] ex_imm,
   output logic [ADDRSIZE-1:0] ex_rd,
   output logic [6:0]          ex_opcode,
   output logic [2:0]          ex_funct3,
   output logic                ex_funct7b5,
   output logic                ex_wen,
   output logic                ex_illegal
);

   localparam int NREG = 1 << ADDRSIZE;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;

   logic [NREG-1:0]     pending;
   logic [NREG-1:0]     pend_eff;
   logic [NREG-1:0]     pending_next;

   logic [6:0]          opcode;
   logic [ADDRSIZE-1:0] rd_dec;
   logic                uses_rs1;
   logic                uses_rs2;
   logic                writes_cls;
   logic                writes_rd;
   logic                illegal;
   logic [31:0]         imm32;
   logic [WORDSIZE-1:0] imm_ext;
   logic                hazard;
   logic                slot_free;
   logic                accept;

   assign opcode = if_instr[6:0];
   assign rd_dec = if_instr[7 +: ADDRSIZE];
   assign rs1    = if_instr[15 +: ADDRSIZE];
   assign rs2    = if_instr[20 +: ADDRSIZE];

   always_comb begin
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
      writes_cls = 1'b0;
      illegal    = 1'b0;
      imm32      = '0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
            uses_rs1   = 1'b1;
            writes_cls = 1'b1;
            imm32      = {{20{if_instr[31]}}, if_instr[31:20]};
         end
         OP_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm32    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
         end
         OP_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                        if_instr[30:25], if_instr[11:8], 1'b0};
         end
         OP_OP, OP_OP32: begin
            uses_rs1   = 1'b1;
            uses_rs2   = 1'b1;
            writes_cls = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            writes_cls = 1'b1;
            imm32      = {if_instr[31:12], 12'b0};
         end
         OP_JAL: begin
            writes_cls = 1'b1;
            imm32      = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                          if_instr[20], if_instr[30:21], 1'b0};
         end
         default: illegal = 1'b1;
      endcase
      writes_rd = writes_cls & (rd_dec != '0);
   end

   assign imm_ext = {{(WORDSIZE-32){imm32[31]}}, imm32};

   // Writeback retiring this cycle is already visible in the regfile read data.
   always_comb begin
      pend_eff = pending;
      if (wb_valid) pend_eff[wb_rd] = 1'b0;
      pend_eff[0] = 1'b0;
   end

   assign hazard    = (uses_rs1 & pend_eff[rs1]) | (uses_rs2 & pend_eff[rs2]) |
                      (writes_rd & pend_eff[rd_dec]);
   assign slot_free = !ex_valid | ex_ready;
   assign if_ready  = slot_free & !hazard & !flush & !rst;
   assign accept    = if_valid & if_ready;

   // Later steps win: wb clear, then flush clear of the held rd, then the new rd set.
   always_comb begin
      pending_next = pend_eff;
      if (flush && ex_valid && ex_wen) pending_next[ex_rd] = 1'b0;
      if (accept && writes_rd) pending_next[rd_dec] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending     <= '0;
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1data  <= '0;
         ex_rs2data  <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_opcode   <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_wen      <= 1'b0;
         ex_illegal  <= 1'b0;
      end else begin
         pending <= pending_next;
         if (accept) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_rs1data  <= rs1data;
            ex_rs2data  <= rs2data;
            ex_imm      <= imm_ext;
            ex_rd       <= rd_dec;
            ex_opcode   <= opcode;
            ex_funct3   <= if_instr[14:12];
            ex_funct7b5 <= if_instr[30];
            ex_wen      <= writes_rd;
            ex_illegal  <= illegal;
         end else if (flush || ex_ready) begin
            ex_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - directed bench for decode_issue_stage
// Register file is modelled in the bench and read combinationally by rs1/rs2.
module tb_decode_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [63:0] rs1data;
   logic [63:0] rs2data;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [63:0] ex_pc;
   logic [63:0] ex_rs1data;
   logic [63:0] ex_rs2data;
   logic [63:0] ex_imm;
   logic [4:0]  ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5;
   logic        ex_wen;
   logic        ex_illegal;

   logic [63:0] rf [32];
   int total = 0;
   int bad = 0;

   assign rs1data = rf[rs1];
   assign rs2data = rf[rs2];

   always #5 clk = ~clk;

   decode_issue_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .rs1(rs1), .rs2(rs2),
      .rs1data(rs1data), .rs2data(rs2data), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .ex_imm(ex_imm),
      .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_wen(ex_wen), .ex_illegal(ex_illegal)
   );

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 64'h10;
      wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; ex_ready = 1'b1;
      #1;
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL reset_if_ready_in_rst: got %0h want 0", if_ready); end
      @(posedge clk); @(posedge clk); #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid: got %0h want 0", ex_valid); end
      total++; if (ex_imm !== 64'h0) begin bad++; $display("FAIL reset_ex_imm: got %h want 0", ex_imm); end
      total++; if (ex_rd !== 5'd0 || ex_wen !== 1'b0) begin bad++; $display("FAIL reset_ex_rd_wen: got %0d/%0h want 0/0", ex_rd, ex_wen); end
      total++; if (dut.pending !== 32'h0) begin bad++; $display("FAIL reset_pending: got %h want 0", dut.pending); end
      @(negedge clk);
      rst = 1'b0; if_valid = 1'b0;
      #1;
      total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready: got %0h want 1", if_ready); end
   endtask

   task automatic test_addi();
      @(negedge clk);
      if_valid = 1'b1; if_instr = 32'hFFF00293; if_pc = 64'h1000; ex_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %0h want 1", ex_valid); end
      total++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL addi_imm: got %h want ffffffffffffffff", ex_imm); end
      total++; if (ex_rd !== 5'd5 || ex_wen !== 1'b1) begin bad++; $display("FAIL addi_rd_wen: got %0d/%0h want 5/1", ex_rd, ex_wen); end
      total++; if (ex_pc !== 64'h1000 || ex_opcode !== 7'h13) begin bad++; $display("FAIL addi_pc_op: got %h/%h want 1000/13", ex_pc, ex_opcode); end
      total++; if (dut.pending[5] !== 1'b1) begin bad++; $display("FAIL addi_pending5: got %0h want 1", dut.pending[5]); end
   endtask

   task automatic test_raw_bypass();
      @(negedge clk);
      if_instr = 32'h00528333; if_pc = 64'h1004;
      #1;
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL raw_stall0: got %0h want 0", if_ready); end
      @(posedge clk); #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL raw_drain: got %0h want 0", ex_valid); end
      @(negedge clk); #1;
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL raw_stall1: got %0h want 0", if_ready); end
      @(negedge clk);
      wb_valid = 1'b1; wb_rd = 5'd5; rf[5] = 64'h0123_4567_89AB_CDEF;
      #1;
      total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL raw_wb_ready: got %0h want 1", if_ready); end
      @(posedge clk); #1;
      total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin bad++; $display("FAIL raw_issue: got %0h/%0d want 1/6", ex_valid, ex_rd); end
      total++; if (ex_rs1data !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL raw_rs1data: got %h want 0123456789abcdef", ex_rs1data); end
      total++; if (ex_rs2data !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL raw_rs2data: got %h want 0123456789abcdef", ex_rs2data); end
      total++; if (dut.pending[5] !== 1'b0 || dut.pending[6] !== 1'b1) begin bad++; $display("FAIL raw_pending: got p5=%0h p6=%0h want 0/1", dut.pending[5], dut.pending[6]); end
   endtask

   task automatic test_hold();
      @(negedge clk);
      wb_valid = 1'b0; ex_ready = 1'b0; if_instr = 32'h123453B7; if_pc = 64'h1008;
      #1;
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL hold_if_ready: got %0h want 0", if_ready); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 64'h1004 || ex_rs1data !== 64'h0123_4567_89AB_CDEF || if_ready !== 1'b0) begin
            bad++; $display("FAIL hold_cycle%0d: got v=%0h rd=%0d pc=%h rdy=%0h want 1/6/1004/0", i, ex_valid, ex_rd, ex_pc, if_ready);
         end
      end
      @(negedge clk);
      ex_ready = 1'b1;
      #1;
      total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %0h want 1", if_ready); end
      @(posedge clk); #1;
      total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_pc !== 64'h1008) begin bad++; $display("FAIL hold_next_issue: got %0h/%0d/%h want 1/7/1008", ex_valid, ex_rd, ex_pc); end
      total++; if (ex_imm !== 64'h0000_0000_1234_5000) begin bad++; $display("FAIL lui_imm: got %h want 12345000", ex_imm); end
      total++; if (dut.pending[7] !== 1'b1) begin bad++; $display("FAIL lui_pending7: got %0h want 1", dut.pending[7]); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      if_valid = 1'b0; ex_ready = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0h want 0", ex_valid); end
      total++; if (dut.pending[7] !== 1'b0 || dut.pending[6] !== 1'b1) begin bad++; $display("FAIL flush_pending: got p7=%0h p6=%0h want 0/1", dut.pending[7], dut.pending[6]); end
      @(negedge clk);
      if_valid = 1'b1; if_instr = 32'hFFF00413; if_pc = 64'h100C;
      #1;
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL flush_if_ready: got %0h want 0", if_ready); end
      @(posedge clk); #1;
      total++; if (ex_valid !== 1'b0 || dut.pending[8] !== 1'b0) begin bad++; $display("FAIL flush_no_accept: got v=%0h p8=%0h want 0/0", ex_valid, dut.pending[8]); end
      @(negedge clk);
      flush = 1'b0; if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd6; ex_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (dut.pending !== 32'h0) begin bad++; $display("FAIL flush_wb_clear: got %h want 0", dut.pending); end
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   task automatic test_formats();
      @(negedge clk);
      if_valid = 1'b1; if_instr = 32'hFE20AE23; if_pc = 64'h2000;
      @(posedge clk); #1;
      total++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL sw_imm: got %h want fffffffffffffffc", ex_imm); end
      total++; if (ex_wen !== 1'b0 || ex_funct3 !== 3'd2 || dut.pending !== 32'h0) begin bad++; $display("FAIL sw_wen_f3_pend: got %0h/%0d/%h want 0/2/0", ex_wen, ex_funct3, dut.pending); end
      total++; if (ex_rs1data !== rf[1] || ex_rs2data !== rf[2]) begin bad++; $display("FAIL sw_operands: got %h/%h want %h/%h", ex_rs1data, ex_rs2data, rf[1], rf[2]); end
      @(negedge clk);
      if_instr = 32'hFE000CE3; if_pc = 64'h2004;
      @(posedge clk); #1;
      total++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFF8 || ex_wen !== 1'b0) begin bad++; $display("FAIL beq_imm: got %h/%0h want fffffffffffffff8/0", ex_imm, ex_wen); end
      @(negedge clk);
      if_instr = 32'h0000007F; if_pc = 64'h2008;
      @(posedge clk); #1;
      total++; if (ex_illegal !== 1'b1 || ex_wen !== 1'b0 || ex_valid !== 1'b1) begin bad++; $display("FAIL illegal: got ill=%0h wen=%0h v=%0h want 1/0/1", ex_illegal, ex_wen, ex_valid); end
      @(negedge clk);
      if_instr = 32'h40100013; if_pc = 64'h200C;
      @(posedge clk); #1;
      total++; if (ex_wen !== 1'b0 || ex_illegal !== 1'b0 || ex_funct7b5 !== 1'b1 || dut.pending !== 32'h0) begin bad++; $display("FAIL addi_x0: got wen=%0h ill=%0h f7=%0h pend=%h want 0/0/1/0", ex_wen, ex_illegal, ex_funct7b5, dut.pending); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      if_instr = 32'hFFDFF0EF; if_pc = 64'h3000;
      @(posedge clk); #1;
      total++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC || ex_rd !== 5'd1 || ex_wen !== 1'b1) begin bad++; $display("FAIL jal: got %h/%0d/%0h want fffffffffffffffc/1/1", ex_imm, ex_rd, ex_wen); end
      @(negedge clk);
      if_instr = 32'hFFF00413; if_pc = 64'h3004;
      #1;
      total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %0h want 1", if_ready); end
      @(posedge clk); #1;
      total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || ex_pc !== 64'h3004) begin bad++; $display("FAIL b2b_issue: got %0h/%0d/%h want 1/8/3004", ex_valid, ex_rd, ex_pc); end
      @(negedge clk);
      if_pc = 64'h3008; wb_valid = 1'b1; wb_rd = 5'd0;
      #1;
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL waw_stall: got %0h want 0", if_ready); end
      @(negedge clk);
      wb_rd = 5'd8;
      #1;
      total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL waw_wb_ready: got %0h want 1", if_ready); end
      @(posedge clk); #1;
      total++; if (ex_pc !== 64'h3008 || dut.pending[8] !== 1'b1 || dut.pending[1] !== 1'b1) begin bad++; $display("FAIL waw_set_wins: got pc=%h p8=%0h p1=%0h want 3008/1/1", ex_pc, dut.pending[8], dut.pending[1]); end
      @(negedge clk);
      if_valid = 1'b0; wb_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 64'h0 : (64'hA5A5_0000_0000_0000 | 64'(i));
      rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
      wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; ex_ready = 1'b1;
      test_reset();
      test_addi();
      test_raw_bypass();
      test_hold();
      test_flush();
      test_formats();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
